// File: rtl/time_entry_if.sv
// Keypad/DIP inputs and committed-time outputs of the time entry controller.
// master drives the pad and switch; slave is the controller.
interface time_entry_if;
    logic        dip_sw;
    logic [9:0]  keypad;
    logic [23:0] set_time;
    logic        load;
    logic [2:0]  entry_pos;
    logic [5:0]  blink_mask;
    logic        busy;
    logic        err;
    logic        timeout;

    modport master (
        output dip_sw, keypad,
        input  set_time, load, entry_pos, blink_mask, busy, err, timeout
    );

    modport slave (
        input  dip_sw, keypad,
        output set_time, load, entry_pos, blink_mask, busy, err, timeout
    );
endinterface

// File: rtl/time_entry_ctrl.sv
// Debounced keypad entry of HH:MM:SS as six range-checked BCD digits,
// committed to the watch counter with a one-cycle load pulse.
module time_entry_ctrl #(
    parameter int DEB_CYC     = 20,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic        clk,
    input  logic        rst,
    time_entry_if.slave bus
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_KEY, CHECK, WAIT_REL, COMMIT
    } state_e;

    state_e         state_q, state_d;
    logic [9:0]     pat_q, pat_d;
    logic [DW-1:0]  deb_q, deb_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [2:0]     pos_q, pos_d;
    logic [23:0]    buf_q, buf_d;
    logic [23:0]    set_q, set_d;

    logic [9:0] inv, key_now;
    logic       valid, stable, counting, in_range;
    logic       load_c, err_c, tmo_c;
    logic [3:0] digit;

    assign inv      = ~bus.keypad;
    assign valid    = (inv != '0) && ((inv & (inv - 10'd1)) == '0);
    // Invalid multi-key patterns debounce exactly like a released pad.
    assign key_now  = valid ? bus.keypad : '1;
    assign stable   = (key_now == pat_q);
    assign counting = ((state_q == WAIT_KEY) || (state_q == WAIT_REL))
                      && (pos_q != 3'd0);

    always_comb begin
        digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (!pat_q[i]) digit = 4'(i);
        end
    end

    always_comb begin
        in_range = 1'b0;
        unique case (pos_q)
            3'd0:       in_range = (digit <= 4'd2);
            3'd1:       in_range = (buf_q[23:20] < 4'd2) ? (digit <= 4'd9)
                                                         : (digit <= 4'd3);
            3'd2, 3'd4: in_range = (digit <= 4'd5);
            3'd3, 3'd5: in_range = (digit <= 4'd9);
            default:    in_range = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        deb_d   = deb_q;
        tmo_d   = tmo_q;
        pos_d   = pos_q;
        buf_d   = buf_q;
        set_d   = set_q;
        load_c  = 1'b0;
        err_c   = 1'b0;
        tmo_c   = 1'b0;
        if (!bus.dip_sw) begin
            state_d = IDLE;
            pos_d   = '0;
            buf_d   = '0;
            deb_d   = '0;
            tmo_d   = '0;
            pat_d   = '1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = WAIT_KEY;
                    pos_d   = '0;
                    buf_d   = '0;
                    pat_d   = '1;
                    deb_d   = '0;
                    tmo_d   = '0;
                end
                WAIT_KEY: begin
                    if (!stable) begin
                        pat_d = key_now;
                        deb_d = DW'(1);
                    end else if (valid && deb_q == DEB_LAST) begin
                        state_d = CHECK;
                    end else if (deb_q < DEB_LAST) begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                CHECK: begin
                    tmo_d   = '0;
                    deb_d   = '0;
                    state_d = WAIT_REL;
                    if (in_range) begin
                        buf_d[4*(5-int'(pos_q)) +: 4] = digit;
                        pos_d = pos_q + 3'd1;
                        if (pos_q == 3'd5) state_d = COMMIT;
                    end else begin
                        err_c = 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (valid) begin
                        deb_d = '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_d = WAIT_KEY;
                        deb_d   = '0;
                        pat_d   = '1;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                COMMIT: begin
                    set_d   = buf_q;
                    load_c  = 1'b1;
                    pos_d   = '0;
                    deb_d   = '0;
                    state_d = WAIT_REL;
                end
                default: state_d = IDLE;
            endcase
            // Idle timer only runs while a partial entry exists.
            if (counting) begin
                if (tmo_q == TMO_LAST) begin
                    tmo_c = 1'b1;
                    buf_d = '0;
                    pos_d = '0;
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end else if (pos_q == 3'd0) begin
                tmo_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '1;
            deb_q   <= '0;
            tmo_q   <= '0;
            pos_q   <= '0;
            buf_q   <= '0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            deb_q   <= deb_d;
            tmo_q   <= tmo_d;
            pos_q   <= pos_d;
            buf_q   <= buf_d;
            set_q   <= set_d;
        end
    end

    assign bus.set_time   = set_q;
    assign bus.load       = load_c;
    assign bus.err        = err_c;
    assign bus.timeout    = tmo_c;
    assign bus.entry_pos  = pos_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.blink_mask = (state_q != IDLE) ? (6'b100000 >> pos_q) : 6'b0;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed bench for time_entry_ctrl: keypad sequences with
// hand-computed digit positions, pulse counts and committed times.
module tb_time_entry_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;
    int   load_n = 0;
    int   err_n = 0;
    int   tmo_n = 0;
    int   load_at = -1;
    int   press_at = 0;

    time_entry_if tif ();

    time_entry_ctrl #(
        .DEB_CYC(20),
        .TIMEOUT_CYC(5000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(tif.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (tif.load === 1'b1) begin
            load_n  = load_n + 1;
            load_at = ncyc;
        end
        if (tif.err === 1'b1) err_n = err_n + 1;
        if (tif.timeout === 1'b1) tmo_n = tmo_n + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k, input int hold, input int rel);
        tif.keypad = ~(10'd1 << k);
        press_at = ncyc;
        cyc(hold);
        tif.keypad = '1;
        cyc(rel);
    endtask

    task automatic dip_cycle();
        tif.dip_sw = 1'b0;
        cyc(2);
        tif.dip_sw = 1'b1;
        cyc(2);
    endtask

    task automatic test_reset();
        tif.dip_sw = 1'b0;
        tif.keypad = '1;
        rst = 1'b1;
        cyc(3);
        checks++;
        if (tif.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", tif.busy);
        end
        checks++;
        if (tif.entry_pos !== 3'd0) begin
            errors++;
            $display("FAIL reset_pos got %0d exp 0", tif.entry_pos);
        end
        checks++;
        if (tif.set_time !== 24'h0) begin
            errors++;
            $display("FAIL reset_time got %h exp 000000", tif.set_time);
        end
        checks++;
        if (tif.blink_mask !== 6'b0) begin
            errors++;
            $display("FAIL reset_blink got %b exp 000000", tif.blink_mask);
        end
        checks++;
        if ({tif.load, tif.err, tif.timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses got %b exp 000",
                     {tif.load, tif.err, tif.timeout});
        end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_full_entry();
        int l0;
        l0 = load_n;
        tif.dip_sw = 1'b1;
        cyc(2);
        checks++;
        if (tif.busy !== 1'b1 || tif.blink_mask !== 6'b100000) begin
            errors++;
            $display("FAIL entry_start got busy %b blink %b exp 1 100000",
                     tif.busy, tif.blink_mask);
        end
        press(1, 30, 30);
        checks++;
        if (tif.entry_pos !== 3'd1 || tif.blink_mask !== 6'b010000) begin
            errors++;
            $display("FAIL entry_pos1 got pos %0d blink %b exp 1 010000",
                     tif.entry_pos, tif.blink_mask);
        end
        press(2, 30, 30);
        press(3, 30, 30);
        press(4, 30, 30);
        press(5, 30, 30);
        press(6, 30, 30);
        checks++;
        if (load_n !== l0 + 1) begin
            errors++;
            $display("FAIL entry_loads got %0d exp %0d", load_n, l0 + 1);
        end
        checks++;
        if (load_at !== press_at + 22) begin
            errors++;
            $display("FAIL entry_latency got %0d exp %0d",
                     load_at, press_at + 22);
        end
        checks++;
        if (tif.set_time !== 24'h123456) begin
            errors++;
            $display("FAIL entry_time got %h exp 123456", tif.set_time);
        end
        checks++;
        if (tif.entry_pos !== 3'd0) begin
            errors++;
            $display("FAIL entry_pos_end got %0d exp 0", tif.entry_pos);
        end
    endtask

    task automatic test_range();
        int e0;
        dip_cycle();
        e0 = err_n;
        press(3, 30, 30);
        checks++;
        if (err_n !== e0 + 1 || tif.entry_pos !== 3'd0) begin
            errors++;
            $display("FAIL range_h_ten got err %0d pos %0d exp %0d 0",
                     err_n, tif.entry_pos, e0 + 1);
        end
        press(2, 30, 30);
        checks++;
        if (tif.entry_pos !== 3'd1 || err_n !== e0 + 1) begin
            errors++;
            $display("FAIL range_two got pos %0d err %0d exp 1 %0d",
                     tif.entry_pos, err_n, e0 + 1);
        end
        press(4, 30, 30);
        checks++;
        if (err_n !== e0 + 2 || tif.entry_pos !== 3'd1) begin
            errors++;
            $display("FAIL range_h_one got err %0d pos %0d exp %0d 1",
                     err_n, tif.entry_pos, e0 + 2);
        end
        press(3, 30, 30);
        checks++;
        if (tif.entry_pos !== 3'd2 || err_n !== e0 + 2) begin
            errors++;
            $display("FAIL range_h_one3 got pos %0d err %0d exp 2 %0d",
                     tif.entry_pos, err_n, e0 + 2);
        end
        press(6, 30, 30);
        checks++;
        if (err_n !== e0 + 3 || tif.entry_pos !== 3'd2) begin
            errors++;
            $display("FAIL range_m_ten got err %0d pos %0d exp %0d 2",
                     err_n, tif.entry_pos, e0 + 3);
        end
    endtask

    task automatic test_debounce();
        int e0;
        dip_cycle();
        e0 = err_n;
        press(1, 30, 30);
        for (int i = 0; i < 5; i++) begin
            tif.keypad = ~(10'd1 << 7);
            cyc(5);
            tif.keypad = '1;
            cyc(5);
        end
        press(7, 30, 30);
        checks++;
        if (tif.entry_pos !== 3'd2 || err_n !== e0) begin
            errors++;
            $display("FAIL bounce got pos %0d err %0d exp 2 %0d",
                     tif.entry_pos, err_n, e0);
        end
        press(5, 500, 30);
        checks++;
        if (tif.entry_pos !== 3'd3 || err_n !== e0) begin
            errors++;
            $display("FAIL hold got pos %0d err %0d exp 3 %0d",
                     tif.entry_pos, err_n, e0);
        end
    endtask

    task automatic test_timeout();
        int l0, t0;
        dip_cycle();
        l0 = load_n;
        t0 = tmo_n;
        press(1, 30, 30);
        press(2, 30, 30);
        checks++;
        if (tif.entry_pos !== 3'd2 || tmo_n !== t0) begin
            errors++;
            $display("FAIL tmo_pre got pos %0d tmo %0d exp 2 %0d",
                     tif.entry_pos, tmo_n, t0);
        end
        cyc(5000);
        checks++;
        if (tmo_n !== t0 + 1) begin
            errors++;
            $display("FAIL tmo_pulse got %0d exp %0d", tmo_n, t0 + 1);
        end
        checks++;
        if (tif.entry_pos !== 3'd0 || tif.busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_state got pos %0d busy %b exp 0 1",
                     tif.entry_pos, tif.busy);
        end
        checks++;
        if (tif.set_time !== 24'h123456 || load_n !== l0) begin
            errors++;
            $display("FAIL tmo_time got %h loads %0d exp 123456 %0d",
                     tif.set_time, load_n, l0);
        end
    endtask

    task automatic test_dip_abort();
        int l0, e0;
        dip_cycle();
        l0 = load_n;
        press(1, 30, 30);
        press(2, 30, 30);
        press(3, 30, 30);
        press(4, 30, 30);
        press(5, 30, 30);
        checks++;
        if (tif.entry_pos !== 3'd5 || tif.blink_mask !== 6'b000001) begin
            errors++;
            $display("FAIL abort_pre got pos %0d blink %b exp 5 000001",
                     tif.entry_pos, tif.blink_mask);
        end
        tif.dip_sw = 1'b0;
        cyc(2);
        checks++;
        if (tif.busy !== 1'b0 || tif.blink_mask !== 6'b0) begin
            errors++;
            $display("FAIL abort_low got busy %b blink %b exp 0 000000",
                     tif.busy, tif.blink_mask);
        end
        tif.dip_sw = 1'b1;
        cyc(2);
        checks++;
        if (tif.busy !== 1'b1 || tif.entry_pos !== 3'd0 || load_n !== l0) begin
            errors++;
            $display("FAIL abort_high got busy %b pos %0d loads %0d exp 1 0 %0d",
                     tif.busy, tif.entry_pos, load_n, l0);
        end
        e0 = err_n;
        tif.keypad = 10'b11_1101_1110;
        cyc(30);
        tif.keypad = '1;
        cyc(30);
        checks++;
        if (tif.entry_pos !== 3'd0 || err_n !== e0) begin
            errors++;
            $display("FAIL multikey got pos %0d err %0d exp 0 %0d",
                     tif.entry_pos, err_n, e0);
        end
    endtask

    task automatic test_reset_mid();
        int l0;
        dip_cycle();
        press(1, 30, 30);
        press(2, 30, 30);
        press(3, 30, 30);
        tif.keypad = ~(10'd1 << 4);
        cyc(30);
        tif.keypad = '1;
        cyc(5);
        rst = 1'b1;
        cyc(1);
        checks++;
        if (tif.busy !== 1'b0 || tif.entry_pos !== 3'd0 ||
            tif.set_time !== 24'h0 || tif.blink_mask !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset got busy %b pos %0d time %h blink %b exp 0 0 000000 000000",
                     tif.busy, tif.entry_pos, tif.set_time, tif.blink_mask);
        end
        rst = 1'b0;
        cyc(2);
        l0 = load_n;
        press(2, 30, 30);
        press(3, 30, 30);
        press(5, 30, 30);
        press(9, 30, 30);
        press(5, 30, 30);
        press(9, 30, 30);
        checks++;
        if (load_n !== l0 + 1 || tif.set_time !== 24'h235959) begin
            errors++;
            $display("FAIL post_reset got loads %0d time %h exp %0d 235959",
                     load_n, tif.set_time, l0 + 1);
        end
        checks++;
        if (load_at !== press_at + 22) begin
            errors++;
            $display("FAIL post_latency got %0d exp %0d",
                     load_at, press_at + 22);
        end
    endtask

    initial begin
        tif.dip_sw = 1'b0;
        tif.keypad = '1;
        test_reset();
        test_full_entry();
        test_range();
        test_debounce();
        test_timeout();
        test_dip_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no end exp finish");
        $fatal(1, "watchdog");
    end

endmodule
